uart_8250_tx: RTL and testbench
===============================

// Module: uart_8250_tx
// PURPOSE
//  Transmit engine of the 8250-compatible UART. Sits directly downstream of the
//  Wishbone register file: takes bytes from the THR via valid/ready and uses the
//  live divisor latch (DLM:DLL) and LCR. Serialises start/data/parity/stop bits on txd.
//  Also supplies the 16x baud tick for the receiver, and THRE/TEMT status to the LSR.
// PARAMETERS
//  OVERSAMPLE  16  baud ticks per bit period (8250 fixed; 1.5 stop = 24 ticks)
//  DIV_W       16  divisor latch width
// PORTS
//  CLK_I       in   1      single system clock
//  RST_I       in   1      one clock; reset is synchronous and active-high
//  divisor     in   DIV_W  {DLM,DLL}; 0 = baud generator stopped
//  lcr         in   8      line control: [1:0] WLS, [2] STB, [3] PEN, [4] EPS, [5] stick, [6] break
//  tx_data     in   8      byte from THR
//  tx_valid    in   1      THR holds a byte
//  tx_ready    out  1      engine can accept; transfer when tx_valid&tx_ready at posedge
//  txd         out  1      serial line, registered, idle high
//  tsr_empty   out  1      shift register idle (LSR TEMT)
//  baud_tick   out  1      one-cycle 16x baud strobe, shared with RX
// BEHAVIOUR
//  Reset (sync, takes priority over everything): txd=1, tx_ready=1, tsr_empty=1, baud_tick=0,
//   FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame; txd=1 after the reset edge.
//  Baud gen: down-counter loads divisor-1. baud_tick=1 for one cycle when it reaches 0, then reloads.
//   divisor=1 -> tick every cycle. divisor=0 -> no ticks; FSM freezes in place.
//   Divisor change takes effect at the next reload.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx_ready=1, tsr_empty=1, txd=1. On handshake, latch tx_data and lcr. Clear the
//    16-tick counter. Go to START; txd=0 from the next edge.
//    LCR writes mid-frame do not affect the current frame.
//   START: 16 ticks. DATA: 5+WLS bits, LSB first, 16 ticks each.
//   PARITY (only if PEN): 16 ticks. Value: stick ? ~EPS : EPS ? ^data : ~^data.
//    XOR is over the active word bits only.
//   STOP: 16 ticks if STB=0. 24 ticks if STB=1 and WLS=0. 32 ticks otherwise.
//    On the last stop tick go to IDLE; tx_ready=1 on the following cycle.
//   tx_ready=0 and tsr_empty=0 in every state except IDLE.
//  Bit boundary: a bit ends on the edge where its 16th (or Nth) tick is counted.
//   txd changes on that same edge, so each bit lasts exactly 16*divisor clocks.
//  Back-to-back: a byte valid while STOP ends is accepted in the first IDLE cycle.
//   The idle gap is exactly 1 clock.
//  Break (lcr[6] live, not latched): txd forced 0 while set. FSM and handshakes keep running.
//   Clearing break restores the FSM-driven txd on the next edge.
//  tx_valid with lcr/divisor unchanged is the only input with handshake semantics.
//   tx_data must be stable while tx_valid=1.
// STRUCTURE
//  Package uart_8250_pkg: LCR bit index localparams (LCR_WLS, LCR_STB, LCR_PEN, LCR_EPS,
//   LCR_STICK, LCR_BRK), OVERSAMPLE, and the TX state encoding.
//   The register file imports the same package.
//  Sub-module uart_baud_gen (divisor -> baud_tick). It is instantiated here and its tick is exported.
//  Remainder: FSM, 5-bit tick counter, 3-bit bit counter, 8-bit shift register, parity accumulator.
// TESTING
//  1. divisor=3, lcr=0x03 (8N1), send 0x12 -> baud_tick every 3 clk. Expected txd: 0,0,1,0,0,1,0,0,0,1,
//     each bit 48 clk. tx_ready low for 480 clk.
//  2. lcr=0x1A (7E1) send 0x55 -> parity bit 0 (four ones). lcr=0x0A (7O1) -> parity 1.
//     lcr=0x2A (stick, EPS=0) -> 1.
//  3. lcr=0x04 (5N1.5), divisor=1, send 0x1F -> start 16 clk, 5 ones 80 clk, stop high 24 clk.
//  4. Back-to-back 0x12 then 0x34 with tx_valid held -> second start bit 1 clk after the first
//     frame's stop ends. tsr_empty pulses 1 for exactly 1 clk.
//  5. Set lcr[6] mid data bit -> txd=0 next edge. Clear it -> frame resumes with the correct
//     bit and timing intact. Change lcr[3] mid-frame -> no parity change.
//  6. Assert RST_I for 1 clk mid-frame -> next edge txd=1, tx_ready=1, tsr_empty=1.
//     divisor=0 -> no baud_tick, txd frozen.

Source files
------------

// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250-compatible UART: LCR field positions, oversampling
// ratio and the transmit FSM encoding. Imported by the register file and the TX engine.
package uart_8250_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   localparam int unsigned LCR_WLS   = 0;  // two bits, [1:0]
   localparam int unsigned LCR_STB   = 2;
   localparam int unsigned LCR_PEN   = 3;
   localparam int unsigned LCR_EPS   = 4;
   localparam int unsigned LCR_STICK = 5;
   localparam int unsigned LCR_BRK   = 6;

   // Last tick index of a normal bit, a 1.5 stop bit and a 2 stop bit.
   localparam logic [4:0] BIT_LAST       = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] STOP_HALF_LAST = 5'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
   localparam logic [4:0] STOP_TWO_LAST  = 5'(2 * OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   function automatic logic [4:0] stop_last_tick(input logic stb, input logic [1:0] wls);
      if (!stb) begin
         return BIT_LAST;
      end
      if (wls == 2'd0) begin
         return STOP_HALF_LAST;
      end
      return STOP_TWO_LAST;
   endfunction

   // xor_acc is the XOR of the transmitted word bits.
   function automatic logic parity_bit(input logic stick, input logic eps, input logic xor_acc);
      if (stick) begin
         return ~eps;
      end
      return eps ? xor_acc : ~xor_acc;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x baud strobe generator: free-running down-counter reloaded from the divisor latch.
// A zero divisor stops the generator with no ticks.
module uart_baud_gen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   output logic             baud_tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (divisor == '0) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         // The divisor is sampled only here, so changes land at the next reload.
         tick_d = 1'b1;
         cnt_d  = divisor - ONE;
      end else begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign baud_tick = tick_q;

endmodule

// File: rtl/uart_8250_tx.sv
// 8250 transmit engine: accepts THR bytes by valid/ready and serialises start, data,
// optional parity and stop bits on txd at 16 baud ticks per bit.
module uart_8250_tx
   import uart_8250_pkg::*;
#(
   parameter int unsigned DIV_W = 16
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic [DIV_W-1:0] divisor,
   input  logic [7:0]       lcr,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             txd,
   output logic             tsr_empty,
   output logic             baud_tick
);

   tx_state_e  state_q, state_d;
   logic [4:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [5:0] frm_q, frm_d;
   logic       txd_q, txd_d;

   logic       tick;
   logic       bit_done;
   logic       line;
   logic [4:0] last_tick;
   logic [2:0] data_last;
   logic       unused_lcr;

   assign unused_lcr = lcr[7];

   uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud_gen (
      .clk       (CLK_I),
      .rst       (RST_I),
      .divisor   (divisor),
      .baud_tick (tick)
   );

   assign baud_tick = tick;
   assign tx_ready  = (state_q == StIdle);
   assign tsr_empty = (state_q == StIdle);
   assign txd       = txd_q;

   assign data_last = 3'd4 + {1'b0, frm_q[LCR_WLS +: 2]};
   assign last_tick = (state_q == StStop) ? stop_last_tick(frm_q[LCR_STB], frm_q[LCR_WLS +: 2])
                                          : BIT_LAST;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      frm_d      = frm_q;
      bit_done   = 1'b0;
      line       = 1'b1;

      // Shared bit timer; the bit ends on the edge that counts its last tick.
      if (tick && state_q != StIdle) begin
         if (tick_cnt_q == last_tick) begin
            tick_cnt_d = '0;
            bit_done   = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
         end
      end

      case (state_q)
         StIdle: begin
            if (tx_valid) begin
               shift_d    = tx_data;
               frm_d      = lcr[5:0];
               par_d      = 1'b0;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d = StData;
            end
         end
         StData: begin
            if (bit_done) begin
               par_d   = par_q ^ shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == data_last) begin
                  state_d = frm_q[LCR_PEN] ? StParity : StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (bit_done) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // txd is registered, so the line level follows the state being entered.
      case (state_d)
         StStart:  line = 1'b0;
         StData:   line = shift_d[0];
         StParity: line = parity_bit(frm_q[LCR_STICK], frm_q[LCR_EPS], par_d);
         default:  line = 1'b1;
      endcase

      txd_d = lcr[LCR_BRK] ? 1'b0 : line;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         frm_q      <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         frm_q      <= frm_d;
         txd_q      <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_8250_tx.sv
// Directed bench for uart_8250_tx: frame timing, parity modes, 1.5 stop, back-to-back,
// break, mid-frame LCR change, reset abort and stopped baud generator.
module tb_uart_8250_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] divisor;
   logic [7:0]  lcr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        txd;
   logic        tsr_empty;
   logic        baud_tick;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_8250_tx #(
      .DIV_W (16)
   ) dut (
      .CLK_I     (clk),
      .RST_I     (rst),
      .divisor   (divisor),
      .lcr       (lcr),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .txd       (txd),
      .tsr_empty (tsr_empty),
      .baud_tick (baud_tick)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Handshake on an edge that carries a baud tick, so the start bit is a full bit long.
   task automatic send(input logic [7:0] d, input string tag);
      int n;
      n = 0;
      while (!(baud_tick === 1'b1 && tx_ready === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_align", tag), {31'b0, baud_tick === 1'b1 && tx_ready === 1'b1}, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check($sformatf("%s_accept", tag), tx_ready, 0);
   endtask

   // Entered in the first clock of the start bit; bits[0] is the start bit, the last is stop.
   task automatic frame(input logic [11:0] bits, input int nbits, input int bit_clk,
                        input int stop_clk, input string tag);
      for (int i = 0; i < nbits; i++) begin
         int len;
         len = (i == nbits - 1) ? stop_clk : bit_clk;
         check($sformatf("%s_b%0d_first", tag, i), txd, bits[i]);
         step(len - 1);
         check($sformatf("%s_b%0d_last", tag, i), txd, bits[i]);
         check($sformatf("%s_b%0d_busy", tag, i), tx_ready, 0);
         check($sformatf("%s_b%0d_tsr", tag, i), tsr_empty, 0);
         step(1);
      end
      check($sformatf("%s_ready", tag), tx_ready, 1);
      check($sformatf("%s_empty", tag), tsr_empty, 1);
      check($sformatf("%s_idle_txd", tag), txd, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      divisor  = 16'd3;
      lcr      = 8'h03;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      rst      = 1'b1;
      step(3);
      check("rst_txd", txd, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_empty", tsr_empty, 1);
      check("rst_tick", baud_tick, 0);
      rst = 1'b0;

      // Baud cadence at divisor 3
      n = 0;
      for (int i = 0; i < 9; i++) begin
         step(1);
         n += int'(baud_tick);
      end
      check("tick_div3_count", n, 3);
      n = 0;
      while (baud_tick !== 1'b1 && n < 10) begin
         step(1);
         n++;
      end
      check("tick_div3_found", baud_tick, 1);
      step(1);
      check("tick_div3_p1", baud_tick, 0);
      step(1);
      check("tick_div3_p2", baud_tick, 0);
      step(1);
      check("tick_div3_p3", baud_tick, 1);

      // 8N1 0x12 at divisor 3: 48 clocks per bit, 480 clocks busy
      send(8'h12, "t1");
      frame(12'h224, 10, 48, 48, "t1");

      // Parity modes at divisor 1
      divisor = 16'd1;
      step(4);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         n += int'(baud_tick);
      end
      check("tick_div1_count", n, 5);
      lcr = 8'h1A;
      send(8'h55, "t2e");
      frame(12'h2AA, 10, 16, 16, "t2e");
      lcr = 8'h0A;
      send(8'h55, "t2o");
      frame(12'h3AA, 10, 16, 16, "t2o");
      lcr = 8'h2A;
      send(8'h55, "t2s");
      frame(12'h3AA, 10, 16, 16, "t2s");

      // 5N1.5
      lcr = 8'h04;
      send(8'h1F, "t3");
      frame(12'h07E, 7, 16, 24, "t3");

      // Back-to-back with tx_valid held
      lcr = 8'h03;
      send(8'h12, "t4a");
      tx_data  = 8'h34;
      tx_valid = 1'b1;
      frame(12'h224, 10, 16, 16, "t4a");
      step(1);
      check("t4_gap_txd", txd, 0);
      check("t4_gap_tsr", tsr_empty, 0);
      tx_valid = 1'b0;
      frame(12'h268, 10, 16, 16, "t4b");

      // Break mid data bit 1, plus a PEN write that must not affect the frame
      lcr = 8'h03;
      send(8'h12, "t5");
      step(34);
      check("t5_pre_brk", txd, 1);
      lcr = 8'h43;
      step(1);
      check("t5_brk", txd, 0);
      lcr = 8'h4B;
      step(5);
      check("t5_brk_hold", txd, 0);
      check("t5_brk_busy", tx_ready, 0);
      lcr = 8'h0B;
      step(1);
      check("t5_unbrk", txd, 1);
      step(6);
      check("t5_b1_end", txd, 1);
      step(1);
      check("t5_b2_start", txd, 0);
      step(32);
      check("t5_b4_start", txd, 1);
      step(64);
      check("t5_stop", txd, 1);
      check("t5_stop_busy", tx_ready, 0);
      step(15);
      check("t5_stop_end_busy", tx_ready, 0);
      step(1);
      check("t5_ready", tx_ready, 1);
      check("t5_idle_txd", txd, 1);
      lcr = 8'h03;

      // Reset mid-frame
      send(8'h12, "t6");
      step(20);
      check("t6_mid_txd", txd, 0);
      rst = 1'b1;
      step(1);
      check("t6_rst_txd", txd, 1);
      check("t6_rst_ready", tx_ready, 1);
      check("t6_rst_empty", tsr_empty, 1);
      check("t6_rst_tick", baud_tick, 0);
      rst = 1'b0;
      step(1);

      // Divisor 0 freezes the frame during data bit 0
      send(8'h12, "t6z");
      step(20);
      check("t6z_mid_txd", txd, 0);
      divisor = 16'd0;
      step(2);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         n += int'(baud_tick);
      end
      check("t6z_no_ticks", n, 0);
      check("t6z_frozen_txd", txd, 0);
      check("t6z_frozen_busy", tx_ready, 0);
      check("t6z_frozen_tsr", tsr_empty, 0);
      divisor = 16'd1;
      rst     = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      check("end_ready", tx_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
